// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the BRAM access arbiter: FSM state encoding,
// read-response latency options and the address-width helper.
package bram_arb_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } arb_state_t;

    // Read latency from grant to response, without and with the BRAM output register.
    localparam int LAT_NOREG  = 1;
    localparam int LAT_OUTREG = 2;

    // Number of bits needed to represent the value 'depth'.
    function automatic int clogb2(input int depth);
        int bits;
        bits = 0;
        for (int d = depth; d > 0; d = d >> 1) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/bram_access_arb_rr_arb2.sv
// Two-input round-robin arbiter: on a tie the requester not granted last wins.
// The last-grant pointer resets to 1 so requester 0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic r_last;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (|grant) begin
            r_last <= grant[1];
        end
    end

endmodule

// File: rtl/bram_access_arb.sv
// Arbitrates one write port and two round-robin read requesters onto a dual-port BRAM,
// with a full-memory zero sweep on reset or clr_start. Define BRAM_ARB_OUTREG_EN for a BRAM with output register.
module bram_access_arb
    import bram_arb_pkg::*;
#(
    parameter  int RAM_WIDTH = 4,
    parameter  int RAM_DEPTH = 64,
    localparam int ADDR_W    = clogb2(RAM_DEPTH - 1)
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 clr_start,
    output logic                 busy,

    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [RAM_WIDTH-1:0] wr_data,

    input  logic                 rd0_valid,
    output logic                 rd0_ready,
    input  logic [ADDR_W-1:0]    rd0_addr,

    input  logic                 rd1_valid,
    output logic                 rd1_ready,
    input  logic [ADDR_W-1:0]    rd1_addr,

    output logic                 rsp_valid,
    output logic                 rsp_id,
    output logic [RAM_WIDTH-1:0] rsp_data,

    output logic                 bram_ena,
    output logic                 bram_wea,
    output logic [ADDR_W-1:0]    bram_addra,
    output logic [RAM_WIDTH-1:0] bram_dina,
    output logic                 bram_enb,
    output logic                 bram_regceb,
    output logic [ADDR_W-1:0]    bram_addrb,
    input  logic [RAM_WIDTH-1:0] bram_doutb
);

`ifdef BRAM_ARB_OUTREG_EN
    localparam int LAT = LAT_OUTREG;
`else
    localparam int LAT = LAT_NOREG;
`endif

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(RAM_DEPTH - 1);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic                w_run;
    logic                w_flush;
    logic [1:0]          w_rd_valid;
    logic [1:0]          w_grant;
    logic [LAT-1:0]      r_pipe_vld;
    logic [LAT-1:0]      r_pipe_id;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; clr_start during CLEAR keeps the FSM in CLEAR while the counter restarts.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CLEAR:   if (!clr_start && (r_clr_cnt == CLR_LAST)) w_state_nxt = RUN;
            RUN:     if (clr_start) w_state_nxt = CLEAR;
            default: w_state_nxt = CLEAR;
        endcase
    end

    // Output logic for port A and the status/ready signals.
    always_comb begin
        busy       = 1'b0;
        wr_ready   = 1'b0;
        w_run      = 1'b0;
        bram_ena   = 1'b0;
        bram_wea   = 1'b0;
        bram_addra = '0;
        bram_dina  = '0;
        case (r_state)
            CLEAR: begin
                busy       = 1'b1;
                bram_ena   = 1'b1;
                bram_wea   = 1'b1;
                bram_addra = r_clr_cnt;
            end
            RUN: begin
                wr_ready = 1'b1;
                w_run    = 1'b1;
                if (wr_valid) begin
                    bram_ena   = 1'b1;
                    bram_wea   = 1'b1;
                    bram_addra = wr_addr;
                    bram_dina  = wr_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || (r_state == RUN) || clr_start || (r_clr_cnt == CLR_LAST)) begin
            r_clr_cnt <= '0;
        end else begin
            r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
        end
    end

    // Port B: reads are only offered to the arbiter while running.
    assign w_rd_valid = {rd1_valid, rd0_valid} & {2{w_run}};

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst   (rst),
        .valid (w_rd_valid),
        .grant (w_grant)
    );

    assign rd0_ready  = w_grant[0];
    assign rd1_ready  = w_grant[1];
    assign bram_enb   = |w_grant;
    assign bram_addrb = w_grant[0] ? rd0_addr :
                        w_grant[1] ? rd1_addr : '0;

    // Starting a sweep kills every response token still travelling through the pipe.
    assign w_flush = w_run && clr_start;

    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_pipe_vld <= '0;
            r_pipe_id  <= '0;
        end else begin
            r_pipe_vld[0] <= |w_grant;
            r_pipe_id[0]  <= w_grant[1];
            for (int i = 1; i < LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_id[i]  <= r_pipe_id[i-1];
            end
        end
    end

`ifdef BRAM_ARB_OUTREG_EN
    assign bram_regceb = r_pipe_vld[0];
`else
    assign bram_regceb = 1'b0;
`endif

    assign rsp_valid = r_pipe_vld[LAT-1];
    assign rsp_id    = r_pipe_id[LAT-1];
    assign rsp_data  = rsp_valid ? bram_doutb : '0;

endmodule
